// File: rtl/gb_ppu_bg_fetcher.sv
// Background/window tile fetcher for the PPU draw path: reads the tile-map entry and
// both bitplanes from VRAM, decodes one 8-pixel row and offers it to the BG pixel FIFO.
module gb_ppu_bg_fetcher (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        fetch_en,
   input  logic        win_mode,
   input  logic [7:0]  lcdc,
   input  logic [7:0]  scx,
   input  logic [7:0]  scy,
   input  logic [7:0]  ly,
   input  logic [7:0]  wly,
   output logic        vram_rd,
   output logic [12:0] vram_addr,
   input  logic [7:0]  vram_rdata,
   output logic        push_valid,
   output logic [31:0] push_pixels,
   input  logic        fifo_empty,
   output logic        busy
);

   // state              | meaning
   // GET_TILE           | read tile index from the active map (2 cycles)
   // GET_TILE_DATA_LOW  | read low bitplane of the tile row (2 cycles)
   // GET_TILE_DATA_HIGH | read high bitplane of the tile row (2 cycles)
   // SLEEP              | idle, no VRAM access (2 cycles)
   // PUSH               | offer 8 pixels; hold until the FIFO is empty

   typedef enum logic [2:0] {
      GET_TILE           = 3'd0,
      GET_TILE_DATA_LOW  = 3'd1,
      GET_TILE_DATA_HIGH = 3'd2,
      SLEEP              = 3'd3,
      PUSH               = 3'd4
   } fifo_pixel_fetcher_state_t;

   typedef struct packed {
      logic lcd_ppu_enable;
      logic win_tile_map;
      logic win_enable;
      logic bg_win_tiles;
      logic bg_tile_map;
      logic obj_size;
      logic obj_enable;
      logic bg_win_enable_priority;
   } lcd_control_t;

   typedef struct packed {
      logic [1:0] color_index;
      logic       obj_palette;
      logic       bg_priority;
   } fifo_pixel_t;

   lcd_control_t              lcdc_s;
   fifo_pixel_fetcher_state_t state, state_n;
   logic                      active, active_n;
   logic                      step, step_n;
   logic [4:0]                fetch_x, fetch_x_n;
   logic                      win, win_n;
   logic [7:0]                tile_idx, lo, hi;

   logic                      run;
   logic [7:0]                bg_y;
   logic [4:0]                bg_col;
   logic                      map_sel;
   logic [2:0]                row;
   logic [12:0]               map_addr;
   logic [12:0]               data_addr;
   logic [31:0]               pixels;
   fifo_pixel_t               px;
   logic                      lcdc_unused;

   assign lcdc_s      = lcd_control_t'(lcdc);
   assign lcdc_unused = ^{lcdc_s.win_enable, lcdc_s.obj_size, lcdc_s.obj_enable, scx[2:0]};
   assign run         = fetch_en & lcdc_s.lcd_ppu_enable;
   assign busy        = active;

   // Map entry: base selects 0x1800/0x1C00, then a 32x32 grid of row-block and column.
   assign bg_y     = ly + scy;
   assign bg_col   = scx[7:3] + fetch_x;
   assign map_sel  = win ? lcdc_s.win_tile_map : lcdc_s.bg_tile_map;
   assign row      = win ? wly[2:0] : bg_y[2:0];
   assign map_addr = {2'b11, map_sel, (win ? wly[7:3] : bg_y[7:3]), (win ? fetch_x : bg_col)};

   // Signed mode: 0x1000 plus a sign-extended 16*tile_idx, wrapping inside 13 bits.
   assign data_addr = lcdc_s.bg_win_tiles
                      ? {1'b0, tile_idx, row, 1'b0}
                      : 13'h1000 + {tile_idx[7], tile_idx, 4'b0000} + {9'd0, row, 1'b0};

   always_comb begin
      pixels = '0;
      px     = '0;
      for (int i = 0; i < 8; i++) begin
         px.color_index = lcdc_s.bg_win_enable_priority ? {hi[7-i], lo[7-i]} : 2'b00;
         px.obj_palette = 1'b0;
         px.bg_priority = 1'b0;
         pixels[31-4*i -: 4] = px;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         state   <= GET_TILE;
         step    <= 1'b0;
         fetch_x <= 5'd0;
         win     <= 1'b0;
      end else begin
         active  <= active_n;
         state   <= state_n;
         step    <= step_n;
         fetch_x <= fetch_x_n;
         win     <= win_n;
      end
   end

   always_comb begin
      active_n  = active;
      state_n   = state;
      step_n    = step;
      fetch_x_n = fetch_x;
      win_n     = win;
      if (!run) begin
         active_n = 1'b0;
      end else if (start) begin
         active_n  = 1'b1;
         state_n   = GET_TILE;
         step_n    = 1'b0;
         fetch_x_n = 5'd0;
         win_n     = win_mode;
      end else if (active) begin
         case (state)
            GET_TILE: begin
               step_n = ~step;
               if (step) state_n = GET_TILE_DATA_LOW;
            end
            GET_TILE_DATA_LOW: begin
               step_n = ~step;
               if (step) state_n = GET_TILE_DATA_HIGH;
            end
            GET_TILE_DATA_HIGH: begin
               step_n = ~step;
               if (step) state_n = SLEEP;
            end
            SLEEP: begin
               step_n = ~step;
               if (step) state_n = PUSH;
            end
            PUSH: begin
               if (fifo_empty) begin
                  state_n   = GET_TILE;
                  step_n    = 1'b0;
                  fetch_x_n = fetch_x + 5'd1;
               end
            end
            default: begin
               state_n = GET_TILE;
               step_n  = 1'b0;
            end
         endcase
      end
   end

   // Read data arrives in the second cycle of each read state and is taken at its closing edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_idx <= 8'd0;
         lo       <= 8'd0;
         hi       <= 8'd0;
      end else if (run && !start && active && step) begin
         case (state)
            GET_TILE:           tile_idx <= vram_rdata;
            GET_TILE_DATA_LOW:  lo       <= vram_rdata;
            GET_TILE_DATA_HIGH: hi       <= vram_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      vram_rd     = 1'b0;
      vram_addr   = 13'd0;
      push_valid  = 1'b0;
      push_pixels = 32'd0;
      if (run && active) begin
         case (state)
            GET_TILE: begin
               vram_rd   = ~step;
               vram_addr = map_addr;
            end
            GET_TILE_DATA_LOW: begin
               vram_rd   = ~step;
               vram_addr = data_addr;
            end
            GET_TILE_DATA_HIGH: begin
               vram_rd   = ~step;
               vram_addr = {data_addr[12:1], 1'b1};
            end
            PUSH: begin
               push_valid  = 1'b1;
               push_pixels = pixels;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gb_ppu_bg_fetcher.sv
// Bench for gb_ppu_bg_fetcher: VRAM responder, per-cycle model of the fetch timeline
// and address/pixel rules, plus directed scenarios with literal expectations.
module tb_gb_ppu_bg_fetcher;
   logic        clk = 1'b0;
   logic        reset, start, fetch_en, win_mode, fifo_empty;
   logic [7:0]  lcdc, scx, scy, ly, wly, vram_rdata;
   logic        vram_rd, push_valid, busy;
   logic [12:0] vram_addr;
   logic [31:0] push_pixels;

   logic [7:0]  mem [0:8191];
   logic [12:0] rd_log [$];
   int          n_cmp = 0;
   int          n_fail = 0;

   logic        m_active;
   int          m_k, m_col;
   logic        m_win;
   logic [7:0]  m_tile, m_lo, m_hi;

   always #5 clk = ~clk;

   gb_ppu_bg_fetcher dut (
      .clk(clk), .reset(reset), .start(start), .fetch_en(fetch_en), .win_mode(win_mode),
      .lcdc(lcdc), .scx(scx), .scy(scy), .ly(ly), .wly(wly),
      .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
      .push_valid(push_valid), .push_pixels(push_pixels), .fifo_empty(fifo_empty), .busy(busy)
   );

   // VRAM: data for a read strobe appears in the following cycle; junk otherwise.
   always @(posedge clk) vram_rdata <= vram_rd ? mem[vram_addr] : 8'hE7;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] f_map(input logic w, input int col);
      int y, base;
      y = (int'(ly) + int'(scy)) % 256;
      if (w) begin
         base = lcdc[6] ? 'h1C00 : 'h1800;
         return 13'(base + 32 * (int'(wly) / 8) + col);
      end
      base = lcdc[3] ? 'h1C00 : 'h1800;
      return 13'(base + 32 * (y / 8) + ((int'(scx) / 8) + col) % 32);
   endfunction

   function automatic int f_row(input logic w);
      return w ? int'(wly) % 8 : ((int'(ly) + int'(scy)) % 256) % 8;
   endfunction

   function automatic logic [12:0] f_data(input logic [7:0] t, input int row);
      int ti;
      ti = int'(t);
      if (lcdc[4]) return 13'(16 * ti + 2 * row);
      if (ti >= 128) ti = ti - 256;
      return 13'(4096 + 16 * ti + 2 * row);
   endfunction

   function automatic logic [31:0] f_pix(input logic [7:0] lo_b, input logic [7:0] hi_b);
      logic [31:0] r;
      int c;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         c = lcdc[0] ? 2 * int'(hi_b[7-i]) + int'(lo_b[7-i]) : 0;
         r = r | (32'(c * 4) << (28 - 4 * i));
      end
      return r;
   endfunction

   // Model: m_k counts cycles since start/transfer (1..9); reads at 1,3,5, push from 9.
   initial begin
      logic run, act, ex_rd, ex_pv;
      logic [12:0] ma, da;
      m_active = 1'b0; m_k = 1; m_col = 0; m_win = 1'b0;
      m_tile = '0; m_lo = '0; m_hi = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_rd", 32'(vram_rd), 32'd0);
            check("rst_push_valid", 32'(push_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            m_active = 1'b0; m_k = 1; m_col = 0;
         end else begin
            run = fetch_en && lcdc[7];
            act = run && m_active;
            ma  = f_map(m_win, m_col);
            if (act && m_k == 1) m_tile = mem[ma];
            da = f_data(m_tile, f_row(m_win));
            if (act && m_k == 3) m_lo = mem[da];
            if (act && m_k == 5) m_hi = mem[da | 13'd1];
            ex_rd = act && (m_k == 1 || m_k == 3 || m_k == 5);
            ex_pv = act && m_k >= 9;
            check("rd", 32'(vram_rd), 32'(ex_rd));
            if (act && m_k <= 2)      check("map_addr", 32'(vram_addr), 32'(ma));
            else if (act && m_k <= 4) check("lo_addr", 32'(vram_addr), 32'(da));
            else if (act && m_k <= 6) check("hi_addr", 32'(vram_addr), 32'(da | 13'd1));
            check("push_valid", 32'(push_valid), 32'(ex_pv));
            if (ex_pv) check("pixels", push_pixels, f_pix(m_lo, m_hi));
            check("busy", 32'(busy), 32'(m_active));
            if (vram_rd) rd_log.push_back(vram_addr);
            if (!run) m_active = 1'b0;
            else if (start) begin
               m_active = 1'b1; m_k = 1; m_col = 0; m_win = win_mode;
            end else if (m_active) begin
               if (m_k < 9) m_k++;
               else if (fifo_empty) begin m_k = 1; m_col = (m_col + 1) % 32; end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic w);
      win_mode = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      win_mode = ~w;
      rd_log.delete();
   endtask

   task automatic wait_push(output int c);
      c = 1;
      while (!push_valid && c < 40) begin
         tick();
         c++;
      end
   endtask

   task automatic check_log3(input string name, input logic [12:0] a0, input logic [12:0] a1,
                             input logic [12:0] a2);
      check({name, "_nreads"}, 32'(rd_log.size()), 32'd3);
      check({name, "_map"}, 32'(rd_log[0]), 32'(a0));
      check({name, "_lo"}, 32'(rd_log[1]), 32'(a1));
      check({name, "_hi"}, 32'(rd_log[2]), 32'(a2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b1; start = 1'b0; fetch_en = 1'b1; win_mode = 1'b0; fifo_empty = 1'b1;
      lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h00; wly = 8'h00;
      for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 37 + 11);
      #1;
      check("reset_rd", 32'(vram_rd), 32'd0);
      check("reset_addr", 32'(vram_addr), 32'd0);
      check("reset_push_valid", 32'(push_valid), 32'd0);
      check("reset_pixels", push_pixels, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // BG, unsigned tile data
      mem['h1800] = 8'h05; mem['h0050] = 8'h3C; mem['h0051] = 8'h7E;
      do_start(1'b0);
      wait_push(c);
      check("t1_push_cycle", 32'(c), 32'd9);
      check_log3("t1", 13'h1800, 13'h0050, 13'h0051);
      check("t1_pixels", push_pixels, 32'h08CCCC80);
      tick();
      check("t1_next_rd", 32'(vram_rd), 32'd1);
      check("t1_next_map", 32'(vram_addr), 32'h1801);

      // Signed tile data
      lcdc = 8'h81; ly = 8'd3;
      mem['h1800] = 8'h80; mem['h1801] = 8'h7F; mem['h0806] = 8'hF0; mem['h0807] = 8'h0F;
      do_start(1'b0);
      wait_push(c);
      check("t2_push_cycle", 32'(c), 32'd9);
      check_log3("t2", 13'h1800, 13'h0806, 13'h0807);
      check("t2_pixels", push_pixels, 32'h44448888);
      for (int i = 0; i < 9; i++) tick();
      check("t2_second_push", 32'(push_valid), 32'd1);
      check("t2_7f_lo", 32'(rd_log[4]), 32'h17F6);
      check("t2_7f_hi", 32'(rd_log[5]), 32'h17F7);

      // Scroll wrap
      lcdc = 8'h91; ly = 8'd5; scx = 8'hF8; scy = 8'hFE;
      mem['h181F] = 8'h02;
      do_start(1'b0);
      wait_push(c);
      check_log3("t3", 13'h181F, 13'h0026, 13'h0027);
      tick();
      check("t3_wrap_rd", 32'(vram_rd), 32'd1);
      check("t3_wrap_map", 32'(vram_addr), 32'h1800);
      scx = 8'h00; scy = 8'h00; ly = 8'h00;

      // Window fetch with backpressure
      lcdc = 8'hF1; wly = 8'd10;
      mem['h1C20] = 8'h10; mem['h0104] = 8'hAA; mem['h0105] = 8'h55;
      fifo_empty = 1'b0;
      do_start(1'b1);
      wait_push(c);
      check("t4_push_cycle", 32'(c), 32'd9);
      check_log3("t4", 13'h1C20, 13'h0104, 13'h0105);
      check("t4_pixels", push_pixels, 32'h48484848);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_stall_valid", 32'(push_valid), 32'd1);
         check("t4_stall_rd", 32'(vram_rd), 32'd0);
         check("t4_stall_pixels", push_pixels, 32'h48484848);
      end
      lcdc = 8'hF0;
      #1;
      check("t4_no_priority", push_pixels, 32'd0);
      lcdc = 8'hF1;
      fifo_empty = 1'b1;
      tick();
      fifo_empty = 1'b0;
      check("t4_accept_rd", 32'(vram_rd), 32'd1);
      check("t4_accept_map", 32'(vram_addr), 32'h1C21);
      check("t4_reads_in_stall", 32'(rd_log.size()), 32'd3);
      fifo_empty = 1'b1;

      // Abort during GET_TILE_DATA_HIGH, then fetch_en drop
      lcdc = 8'h91; wly = 8'd0;
      do_start(1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("t5_high_rd", 32'(vram_rd), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_abort_rd", 32'(vram_rd), 32'd1);
      check("t5_abort_map", 32'(vram_addr), 32'h1800);
      fetch_en = 1'b0;
      #1;
      check("t5_en_low_rd", 32'(vram_rd), 32'd0);
      fetch_en = 1'b1;
      fifo_empty = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t5_push", 32'(push_valid), 32'd1);
      fetch_en = 1'b0;
      #1;
      check("t5_en_low_push", 32'(push_valid), 32'd0);
      tick();
      check("t5_busy_cleared", 32'(busy), 32'd0);
      fetch_en = 1'b1;
      tick();
      check("t5_stays_idle", 32'(busy), 32'd0);

      // Async reset mid-push
      do_start(1'b0);
      wait_push(c);
      check("t6_push_cycle", 32'(c), 32'd9);
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_rd", 32'(vram_rd), 32'd0);
      check("t6_rst_addr", 32'(vram_addr), 32'd0);
      check("t6_rst_push_valid", 32'(push_valid), 32'd0);
      check("t6_rst_pixels", push_pixels, 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      fifo_empty = 1'b1;
      tick();
      do_start(1'b0);
      check("t6_restart_rd", 32'(vram_rd), 32'd1);
      check("t6_restart_map", 32'(vram_addr), 32'h1800);
      wait_push(c);
      check("t6_restart_push", 32'(c), 32'd9);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/gb_ppu_bg_fetcher.md
# gb_ppu_bg_fetcher

Background/window pixel fetcher for the PPU's DRAW_PIXEL (mode 3) path. It walks the active tile map, reads the tile index and the two tile-data bitplanes from VRAM, and decodes one 8-pixel row. It then pushes that row as eight `fifo_pixel_t` entries into the background pixel FIFO, which sits directly downstream. The sequence follows the `fifo_pixel_fetcher_state_t` steps GET_TILE → GET_TILE_DATA_LOW → GET_TILE_DATA_HIGH → SLEEP → PUSH.

## Interface
- No parameters.
- `clk`  in  1  PPU dot clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse: restart fetching at tile column 0. Issued at mode-3 entry and at window trigger.
- `fetch_en`  in  1  level: fetcher may run. Low during OAM_SCAN, HBLANK and VBLANK.
- `win_mode`  in  1  0 = background fetch, 1 = window fetch. Sampled at `start`.
- `lcdc`  in  8  `lcd_control_t`.
- `scx`, `scy`  in  8 each  scroll registers, read live at each step.
- `ly`  in  8  current line.
- `wly`  in  8  internal window line counter.
- `vram_rd`  out  1  VRAM read strobe.
- `vram_addr`  out  13  VRAM byte offset from 0x8000.
- `vram_rdata`  in  8  read data, valid in the cycle after the `vram_rd` cycle.
- `push_valid`  out  1  eight decoded pixels ready.
- `push_pixels`  out  32  8 × `fifo_pixel_t`; [31:28] = leftmost pixel.
- `fifo_empty`  in  1  downstream FIFO empty; a transfer happens on `push_valid && fifo_empty`.
- `busy`  out  1  fetcher active.

## Operation
- Registered state:
  - `active`: 1 bit.
  - `state`: `fifo_pixel_fetcher_state_t`.
  - `step`: 1 bit, the sub-cycle within a 2-cycle state.
  - `fetch_x`: 5 bits.
  - `tile_idx`, `lo`, `hi`: 8 bits each.
  - `win`: 1 bit.
- `start` (while `fetch_en` = 1 and `lcdc.lcd_ppu_enable` = 1):
  - Sets `active`=1, `state`=GET_TILE, `step`=0, `fetch_x`=0, `win`=`win_mode`.
  - Aborts any fetch in progress.
- `fetch_en` = 0 or `lcdc.lcd_ppu_enable` = 0:
  - `vram_rd` and `push_valid` are forced low combinationally.
  - `active` clears at the next edge.
- GET_TILE, GET_TILE_DATA_LOW, GET_TILE_DATA_HIGH each take 2 cycles:
  - step 0: `vram_rd`=1 and the address is driven.
  - step 1: `vram_rd`=0, the address is held, and `vram_rdata` is captured at the closing edge into `tile_idx`, `lo` or `hi` respectively.
- SLEEP: 2 cycles, no VRAM access.
- PUSH:
  - `push_valid`=1. The state holds until `fifo_empty`=1.
  - On transfer: `fetch_x` ← `fetch_x`+1 (mod 32), `state` ← GET_TILE.
- Map address:
  - BG: `(lcdc.bg_tile_map ? 0x1C00 : 0x1800) + 32*(((ly+scy) mod 256)>>3) + (((scx>>3)+fetch_x) mod 32)`.
  - Window: `(lcdc.win_tile_map ? 0x1C00 : 0x1800) + 32*(wly>>3) + fetch_x`.
- Row number: BG uses `(ly+scy) mod 8`; window uses `wly mod 8`.
- Data address:
  - `lcdc.bg_win_tiles`=1: `16*tile_idx + 2*row`.
  - `lcdc.bg_win_tiles`=0: `0x1000 + 16*signed(tile_idx) + 2*row`.
  - In both modes, the HIGH step uses the data address +1.
- Pixel i (0 = leftmost):
  - `color_index` = `{hi[7-i], lo[7-i]}`; `obj_palette`=0; `bg_priority`=0.
  - If `lcdc.bg_win_enable_priority`=0, every `color_index` is 0.

## Timing
- Reset values:
  - Outputs: `vram_rd`=0, `vram_addr`=0, `push_valid`=0, `push_pixels`=0, `busy`=0.
  - State: `state`=GET_TILE, `step`=0, `fetch_x`=0.
  - Outputs clear immediately on reset assertion.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples `start`.
  - `vram_rd` is high in cycles 1, 3 and 5.
  - `push_valid` is high from cycle 9.
  - With `fifo_empty`=1, the next map read is in cycle 10; steady state is 9 cycles per tile.
- `push_pixels` is stable while `push_valid`=1. No VRAM reads occur while stalled in PUSH.
- `start` in the same cycle as a transfer:
  - The transfer completes (the FIFO owner flushes on `start`).
  - `start` wins for all fetcher state.
- `busy` = `active`.

## Test plan
- BG fetch, normal tile addressing:
  - Stimulus: `lcdc`=0x91, `scx`=`scy`=`ly`=0, VRAM[0x1800]=0x05, VRAM[0x0050]=0x3C, VRAM[0x0051]=0x7E.
  - Response: reads at 0x1800, 0x0050, 0x0051; `push_valid` in cycle 9; colors left→right 0,2,3,3,3,3,2,0.
- Signed tile addressing:
  - Stimulus: `lcdc`=0x81, `ly`=3, tile 0x80.
  - Response: data reads at 0x0806/0x0807. Tile 0x7F reads at 0x17F6/0x17F7.
- Scroll wrap:
  - Stimulus: `scx`=0xF8, `scy`=0xFE, `ly`=5.
  - Response: first map read 0x181F, row 3; second map read 0x1800.
- Window fetch:
  - Stimulus: `lcdc`=0xF1, `win_mode`=1, `wly`=10.
  - Response: map read 0x1C20, row 2. `lcdc.bg_win_enable_priority`=0 gives all colors 0.
- Backpressure:
  - Stimulus: `fifo_empty`=0 for 5 cycles at PUSH.
  - Response: `push_valid` and pixels held, `vram_rd`=0, `fetch_x` unchanged; next map read 1 cycle after acceptance at column+1.
- Abort and reset:
  - `start` during GET_TILE_DATA_HIGH → next cycle `vram_rd`=1 at the column-0 map address.
  - Async `reset` mid-fetch → all outputs 0 before the next edge.
  - `fetch_en` low → `vram_rd`/`push_valid` low in the same cycle.
